scope_cmd_rx: RTL and testbench

//  Host-to-FPGA command decoder for the oscilloscope. Consumes bytes from the AVR serial

---
 rtl/scope_cmd_pkg.sv | 21 ++
 rtl/scope_tx_byte_issuer.sv | 40 ++++
 rtl/scope_cmd_rx.sv | 165 ++++++++++++++++
 tb/tb_scope_cmd_rx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_cmd_pkg.sv
// Shared types and constants for the scope host command decoder.
package scope_cmd_pkg;

   localparam int REG_ADDR_W = 7;
   localparam int REG_DATA_W = 16;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_DHI, ST_DLO, ST_CHK,
      ST_EXEC, ST_RD_WAIT, ST_TX_ACK, ST_TX_RHI, ST_TX_RLO
   } state_e;

   // States in which an arriving byte cannot be parsed and is discarded.
   function automatic logic is_reply_state(input state_e s);
      return s inside {ST_EXEC, ST_RD_WAIT, ST_TX_ACK, ST_TX_RHI, ST_TX_RLO};
   endfunction

endpackage

// File: rtl/scope_tx_byte_issuer.sv
// Turns a held byte request into one new_tx_data pulse, then blocks for the pulse
// cycle and one guard cycle before honouring tx_busy again. Issue latency: 1 cycle.
module scope_tx_byte_issuer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_vld,
   input  logic [7:0] req_dat,
   output logic       req_ack,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       new_tx_data
);

   logic       new_tx_q, new_tx_d;
   logic       guard_q, guard_d;
   logic [7:0] tx_data_q, tx_data_d;

   always_comb begin
      req_ack   = req_vld && !new_tx_q && !guard_q && !tx_busy;
      new_tx_d  = req_ack;
      guard_d   = new_tx_q;
      tx_data_d = req_ack ? req_dat : tx_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_tx_q  <= 1'b0;
         guard_q   <= 1'b0;
         tx_data_q <= '0;
      end else begin
         new_tx_q  <= new_tx_d;
         guard_q   <= guard_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign new_tx_data = new_tx_q;
   assign tx_data     = tx_data_q;

endmodule

// File: rtl/scope_cmd_rx.sv
// Parses SYNC/ADDR/DHI/DLO/CHK frames into register bus accesses and replies ACK/NAK (plus read data).
// Latency: reg_we/reg_re one cycle after the CHK strobe; reply issued via scope_tx_byte_issuer.
// Backpressure: replies wait on tx_busy; bytes arriving during EXEC/RD_WAIT/TX_* are dropped (rx_drop).
module scope_cmd_rx
    import scope_cmd_pkg::*;
    #(parameter int TIMEOUT_CYCLES = 500000)
    (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  new_rx_data,
    output logic [7:0]            tx_data,
    output logic                  new_tx_data,
    input  logic                  tx_busy,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [REG_DATA_W-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [REG_DATA_W-1:0] reg_rdata,
    output logic                  rx_drop
);

    state_e                state_q, state_d;
    logic [7:0]            addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d, xor_q, xor_d;
    logic                  nak_q, nak_d;
    logic [REG_DATA_W-1:0] hold_q, hold_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [REG_DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic                  reg_we_q, reg_we_d, reg_re_q, reg_re_d, rx_drop_q, rx_drop_d;
    logic                  req_vld, req_ack;
    logic [7:0]            req_dat;
`ifdef CMD_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0]           to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        req_vld = state_q inside {ST_TX_ACK, ST_TX_RHI, ST_TX_RLO};
        case (state_q)
            ST_TX_RHI: req_dat = hold_q[15:8];
            ST_TX_RLO: req_dat = hold_q[7:0];
            default:   req_dat = nak_q ? NAK_BYTE : ACK_BYTE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        dlo_d       = dlo_q;
        xor_d       = xor_q;
        nak_d       = nak_q;
        hold_d      = hold_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        rx_drop_d   = new_rx_data && is_reply_state(state_q);
        case (state_q)
            ST_IDLE: if (new_rx_data && rx_data == SYNC_BYTE) begin
                state_d = ST_ADDR;
                xor_d   = '0;
                nak_d   = 1'b0;
            end
            ST_ADDR: if (new_rx_data) begin
                addr_d  = rx_data;
                xor_d   = xor_q ^ rx_data;
                state_d = ST_DHI;
            end
            ST_DHI: if (new_rx_data) begin
                dhi_d   = rx_data;
                xor_d   = xor_q ^ rx_data;
                state_d = ST_DLO;
            end
            ST_DLO: if (new_rx_data) begin
                dlo_d   = rx_data;
                xor_d   = xor_q ^ rx_data;
                state_d = ST_CHK;
            end
            // Bus strobe and its address/data are registered on the same edge as EXEC entry.
            ST_CHK: if (new_rx_data) begin
                if (rx_data == xor_q) begin
                    state_d     = ST_EXEC;
                    reg_addr_d  = addr_q[6:0];
                    reg_wdata_d = {dhi_q, dlo_q};
                    reg_we_d    = !addr_q[7];
                    reg_re_d    = addr_q[7];
                end else begin
                    nak_d   = 1'b1;
                    state_d = ST_TX_ACK;
                end
            end
            ST_EXEC:    state_d = addr_q[7] ? ST_RD_WAIT : ST_TX_ACK;
            ST_RD_WAIT: begin
                hold_d  = reg_rdata;
                state_d = ST_TX_ACK;
            end
            ST_TX_ACK: if (req_ack) state_d = (addr_q[7] && !nak_q) ? ST_TX_RHI : ST_IDLE;
            ST_TX_RHI: if (req_ack) state_d = ST_TX_RLO;
            ST_TX_RLO: if (req_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
`ifdef CMD_TIMEOUT_EN
        to_cnt_d = '0;
        if (state_q inside {ST_ADDR, ST_DHI, ST_DLO, ST_CHK} && !new_rx_data) begin
            if (to_cnt_q == TO_LAST) state_d = ST_IDLE;
            else                     to_cnt_d = to_cnt_q + 20'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            xor_q       <= '0;
            nak_q       <= 1'b0;
            hold_q      <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            rx_drop_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            dlo_q       <= dlo_d;
            xor_q       <= xor_d;
            nak_q       <= nak_d;
            hold_q      <= hold_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            rx_drop_q   <= rx_drop_d;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign rx_drop   = rx_drop_q;

    scope_tx_byte_issuer u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_dat    (req_dat),
        .req_ack    (req_ack),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data)
    );

endmodule

// File: tb/tb_scope_cmd_rx.sv
// Randomized frame stimulus against a byte-level frame model with a per-cycle checker.
// Latency: checks reg_we/reg_re one cycle after the CHK byte and reply bytes in order.
// Backpressure: models a transmitter holding tx_busy for busy_len cycles per byte.
module tb_scope_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        new_rx_data = 1'b0;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy = 1'b0;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we, reg_re;
    logic [15:0] reg_rdata = '0;
    logic        rx_drop;

    always #5 clk = ~clk;

    scope_cmd_rx #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .rx_drop(rx_drop)
    );

    typedef struct { bit rd; logic [6:0] addr; logic [15:0] wdata; } op_t;

    int          total = 0, bad = 0;
    int          drops_seen = 0, exp_drops = 0, tx_cnt = 0;
    int          busy_len = 100;
    op_t         exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] mmem [128];
    logic [15:0] smem [128];
    logic [6:0]  last_addr = '0;
    int          m_pos = 0;
    logic [7:0]  m_buf [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: whole frames in, expected bus ops and reply bytes out.
    task automatic frame_done();
        logic [7:0] a, h, l, c;
        op_t o;
        a = m_buf[0]; h = m_buf[1]; l = m_buf[2]; c = m_buf[3];
        if (c != (a ^ h ^ l)) begin
            exp_tx.push_back(8'h15);
        end else begin
            o.rd = a[7]; o.addr = a[6:0]; o.wdata = {h, l};
            exp_bus.push_back(o);
            exp_tx.push_back(8'h06);
            if (a[7]) begin
                exp_tx.push_back(mmem[a[6:0]][15:8]);
                exp_tx.push_back(mmem[a[6:0]][7:0]);
            end else begin
                mmem[a[6:0]] = {h, l};
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pos == 0) begin
            if (b == 8'hA5) m_pos = 1;
        end else begin
            m_buf[m_pos-1] = b;
            if (m_pos == 4) begin
                frame_done();
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit feed, input int gap);
        if (feed) model_byte(b);
        @(posedge clk); #1;
        rx_data = b; new_rx_data = 1'b1;
        @(posedge clk); #1;
        new_rx_data = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] c);
        send_byte(8'hA5, 1, 1);
        send_byte(a, 1, 2);
        send_byte(h, 1, 0);
        send_byte(l, 1, 3);
        send_byte(c, 1, 0);
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_tx.size() == 0 && exp_bus.size() == 0 && !tx_busy) begin
                done = 1;
                break;
            end
        end
        chk("reply_complete", 32'(done), 32'd1);
        repeat (3) @(posedge clk);
    endtask

    // Register slave: read data is valid only in the cycle after reg_re.
    initial begin
        logic        re_s, we_s;
        logic [6:0]  a_s;
        logic [15:0] wd_s;
        forever begin
            @(negedge clk);
            re_s = reg_re; we_s = reg_we; a_s = reg_addr; wd_s = reg_wdata;
            @(posedge clk); #1;
            reg_rdata = re_s ? smem[a_s] : 16'hDEAD;
            if (we_s) smem[a_s] = wd_s;
        end
    end

    // Transmitter: busy for busy_len cycles after each accepted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && new_tx_data) begin
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model queues.
    initial begin
        op_t o;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (new_tx_data) begin
                    tx_cnt++;
                    chk("tx_while_busy", 32'(tx_busy), 32'd0);
                    if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    else                    chk("tx_spurious", 32'(new_tx_data), 32'd0);
                end
                if (reg_we || reg_re) begin
                    chk("we_re_exclusive", 32'(reg_we & reg_re), 32'd0);
                    if (exp_bus.size() != 0) begin
                        o = exp_bus.pop_front();
                        chk("bus_is_read", 32'(reg_re), 32'(o.rd));
                        chk("bus_addr", 32'(reg_addr), 32'(o.addr));
                        if (!o.rd) chk("bus_wdata", 32'(reg_wdata), 32'(o.wdata));
                        last_addr = o.addr;
                    end else begin
                        chk("bus_spurious", 32'(reg_we | reg_re), 32'd0);
                    end
                end else begin
                    chk("addr_stable", 32'(reg_addr), 32'(last_addr));
                end
                if (rx_drop) drops_seen++;
            end
        end
    end

    initial begin
        logic [7:0] a, h, l, c, j;
        int n;
        for (int i = 0; i < 128; i++) begin
            mmem[i] = 16'(i * 257 + 3);
            smem[i] = 16'(i * 257 + 3);
        end
        mmem[5] = 16'hBEEF;     smem[5] = 16'hBEEF;
        mmem[7'h25] = 16'hC0DE; smem[7'h25] = 16'hC0DE;

        #2;
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_new_tx", 32'(new_tx_data), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_we_re", 32'({reg_we, reg_re}), 32'd0);
        chk("rst_rx_drop", 32'(rx_drop), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write frame.
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        chk("wr_we_latency", 32'(reg_we), 32'd1);
        chk("wr_model_tx", 32'(exp_tx[0]), 32'h06);
        chk("wr_model_wdata", 32'(exp_bus[0].wdata), 32'h1234);
        wait_done();
        chk("wr_slave_mem", 32'(smem[3]), 32'h1234);

        // Bad checksum.
        send_frame(8'h03, 8'h12, 8'h34, 8'h00);
        chk("nak_model_tx", 32'(exp_tx[0]), 32'h15);
        chk("nak_model_nobus", 32'(exp_bus.size()), 32'd0);
        wait_done();

        // Read frame, 100-cycle busy per byte.
        send_frame(8'h85, 8'h00, 8'h00, 8'h85);
        chk("rd_re_latency", 32'(reg_re), 32'd1);
        chk("rd_model_tx", {8'h0, exp_tx[0], exp_tx[1], exp_tx[2]}, 32'h0006BEEF);
        wait_done();

        // Junk then A5 A5 00 00 A5 -> read of 0x25.
        foreach (m_buf[i]) m_buf[i] = '0;
        send_byte(8'h00, 1, 1);
        send_byte(8'hFF, 1, 1);
        send_byte(8'hA5, 1, 0);
        send_byte(8'hA5, 1, 0);
        send_byte(8'h00, 1, 0);
        send_byte(8'h00, 1, 0);
        send_byte(8'hA5, 1, 0);
        chk("junk_model_addr", 32'(exp_bus[0].addr), 32'h25);
        chk("junk_model_rdata", {exp_tx[1], exp_tx[2]}, 32'hC0DE);
        wait_done();

        // Bytes arriving in EXEC/RD_WAIT and during the reply are dropped.
        send_frame(8'h85, 8'h00, 8'h00, 8'h85);
        send_byte(8'hA5, 0, 20);
        exp_drops++;
        send_byte(8'hA5, 0, 0);
        exp_drops++;
        wait_done();
        chk("drop_count", 32'(drops_seen), 32'(exp_drops));
        send_frame(8'h11, 8'hAB, 8'hCD, 8'h11 ^ 8'hAB ^ 8'hCD);
        wait_done();
        send_frame(8'h91, 8'h00, 8'h00, 8'h91);
        chk("drop_then_read_model", {exp_tx[1], exp_tx[2]}, 32'hABCD);
        wait_done();

        // Randomized frames with junk and variable busy.
        for (int f = 0; f < 40; f++) begin
            busy_len = $urandom_range(1, 100);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j, 1, $urandom_range(0, 2));
            end
            a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            c = a ^ h ^ l;
            if ($urandom_range(0, 4) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
            send_frame(a, h, l, c);
            wait_done();
        end
        busy_len = 100;

        // Reset in the middle of a read reply.
        send_frame(8'h85, 8'h00, 8'h00, 8'h85);
        for (int i = 0; i < 500 && exp_tx.size() > 2; i++) @(posedge clk);
        chk("rr_ack_sent", 32'(exp_tx.size()), 32'd2);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_tx.delete(); exp_bus.delete(); m_pos = 0; last_addr = '0;
        #1;
        chk("rr_new_tx_low", 32'(new_tx_data), 32'd0);
        chk("rr_reg_addr", 32'(reg_addr), 32'd0);
        n = tx_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        chk("rr_no_tx_after_reset", 32'(tx_cnt), 32'(n));

`ifdef CMD_TIMEOUT_EN
        // Partial frame abandoned after the idle timeout.
        n = tx_cnt;
        send_byte(8'hA5, 1, 0);
        send_byte(8'h03, 1, 100);
        m_pos = 0;
        send_byte(8'h12, 1, 0);
        send_byte(8'h34, 1, 0);
        send_byte(8'h25, 1, 50);
        chk("to_no_reply", 32'(tx_cnt), 32'(n));
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        wait_done();
`endif

        chk("final_tx_queue", 32'(exp_tx.size()), 32'd0);
        chk("final_bus_queue", 32'(exp_bus.size()), 32'd0);
        chk("final_drops", 32'(drops_seen), 32'(exp_drops));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
